// File: rtl/sub_16bit_csel_seq.sv
// Sequential carry-select subtractor: a - b - bin, one BLOCK-wide slice per cycle,
// with valid/ready handshakes on both sides and borrow / signed-overflow flags.
module sub_16bit_csel_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / BLOCK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bn_q, bn_d;
  logic             c_q, c_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [BLOCK:0]   r0, r1, sel;
  int unsigned      base;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bn_d    = bn_q;
    c_d     = c_q;
    k_d     = k_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    base    = 0;
    r0      = '0;
    r1      = '0;
    sel     = '0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          bn_d    = ~b;
          c_d     = ~bin;
          k_d     = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        base = 32'(k_q) * BLOCK;
        // Both carry-in candidates are formed, the registered carry picks one.
        r0   = {1'b0, a_q[base+:BLOCK]} + {1'b0, bn_q[base+:BLOCK]};
        r1   = {1'b0, a_q[base+:BLOCK]} + {1'b0, bn_q[base+:BLOCK]} + {{BLOCK{1'b0}}, 1'b1};
        sel  = c_q ? r1 : r0;
        diff_d[base+:BLOCK] = sel[BLOCK-1:0];
        c_d  = sel[BLOCK];
        if (k_q == KLast) begin
          state_d = StDone;
          bout_d  = ~sel[BLOCK];
          // bn_q holds ~b, so equal MSBs here means a and b MSBs differ.
          ovf_d   = (a_q[WIDTH-1] == bn_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      bn_q    <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bn_q    <= bn_d;
      c_q     <= c_d;
      k_q     <= k_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub_16bit_csel_seq.sv
// Bench for sub_16bit_csel_seq: vector table, backpressure, mid-op reset and a random
// run, all scored against expectations queued at the accepting edge.
module tb_sub_16bit_csel_seq;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  sub_16bit_csel_seq #(.WIDTH(16), .BLOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
    logic [16:0] full;
    exp_t        e;
    full = {1'b0, ma} - {1'b0, mb} - {16'b0, mbin};
    e.d  = full[15:0];
    e.bo = full[16];
    e.ov = (ma[15] != mb[15]) && (full[15] != ma[15]);
    return e;
  endfunction

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                      input exp_t e);
    int n;
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", {31'b0, in_ready}, 32'd1);
    tick();
    sb.push_back(e);
    in_valid = 1'b0;
    // Scramble operands after the accepting edge; they must not matter.
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_scoreboard: got a result, expected none queued", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_diff"}, {16'b0, diff}, {16'b0, e.d});
      check({tag, "_bout"}, {31'b0, bout}, {31'b0, e.bo});
      check({tag, "_ovf"},  {31'b0, ovf},  {31'b0, e.ov});
    end
  endtask

  task automatic collect(input string tag, input int stall);
    int lat;
    lat = 0;
    out_ready = (stall == 0);
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(N));
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    check_result(tag);
    tick();
    check({tag, "_consumed"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  vec_t vecs[7];
  exp_t e;

  initial begin
    vecs[0] = '{a: 16'h1234, b: 16'h0234, bin: 1'b0, d: 16'h1000, bo: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 16'h0000, b: 16'h0001, bin: 1'b0, d: 16'hFFFF, bo: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 16'h8000, b: 16'h0001, bin: 1'b0, d: 16'h7FFF, bo: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 16'h0005, b: 16'h0003, bin: 1'b1, d: 16'h0001, bo: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 16'h0000, b: 16'hFFFF, bin: 1'b1, d: 16'h0000, bo: 1'b1, ov: 1'b0};
    vecs[5] = '{a: 16'h7FFF, b: 16'hFFFF, bin: 1'b0, d: 16'h8000, bo: 1'b1, ov: 1'b1};
    vecs[6] = '{a: 16'hFFFF, b: 16'hFFFF, bin: 1'b1, d: 16'hFFFF, bo: 1'b1, ov: 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 16'hA5A5; b = 16'h5A5A; bin = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_diff",      {16'b0, diff},      32'd0);
    check("rst_bout",      {31'b0, bout},      32'd0);
    check("rst_ovf",       {31'b0, ovf},       32'd0);

    foreach (vecs[i]) begin
      e.d = vecs[i].d; e.bo = vecs[i].bo; e.ov = vecs[i].ov;
      send(vecs[i].a, vecs[i].b, vecs[i].bin, e);
      collect($sformatf("vec%0d", i), 0);
    end

    // Backpressure: stall in DONE while inputs and in_valid wiggle.
    e.d = 16'h0123; e.bo = 1'b0; e.ov = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, e);
    out_ready = 1'b0;
    repeat (N) tick();
    check("bp_valid_start", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); in_valid = ~in_valid;
      tick();
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_diff", {16'b0, diff}, 32'h0123);
      check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_result("bp");
    tick();
    check("bp_consumed", {31'b0, out_valid}, 32'd0);
    repeat (6) tick();
    check("bp_single_result", {31'b0, out_valid}, 32'd0);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during CALC slice 2 discards the operation.
    e = model(16'h1111, 16'h2222, 1'b0);
    send(16'h1111, 16'h2222, 1'b0, e);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_front());
    check("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_diff",      {16'b0, diff},      32'd0);
    check("mid_rst_bout",      {31'b0, bout},      32'd0);
    check("mid_rst_ovf",       {31'b0, ovf},       32'd0);
    repeat (6) tick();
    check("mid_rst_no_result", {31'b0, out_valid}, 32'd0);
    e.d = 16'h00F0; e.bo = 1'b0; e.ov = 1'b0;
    send(16'h00FF, 16'h000F, 1'b0, e);
    collect("post_rst", 0);

    // Random back-to-back traffic with occasional output stalls.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ra, rb;
      logic        rbin;
      int          stall;
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        ra = 16'($urandom_range(0, 1)) ? 16'h8000 : 16'h7FFF;
      end
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      send(ra, rb, rbin, model(ra, rb, rbin));
      collect("rand", stall);
    end

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
